// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler
//   Front end for the serial DAC controller. Keeps a 12-bit shadow value and
//   a pending bit for each channel A..D. Pending channels are served one at a
//   time in round-robin order through the data/address/command/dactrig/dacdone
//   handshake. In sync mode every pending channel is loaded without updating
//   its output, and one update-all command then changes the outputs together.
//
// Ports
//   CLK50MHZ     system clock, rising edge
//   RST          synchronous active-high reset
//   wr_en        one-cycle write strobe for wr_chan / wr_data
//   wr_chan      target channel, 0..3 = A..D
//   wr_data      new channel value
//   sync_mode    0 = write-and-update, 1 = load all then update all
//   err_clr      clears err_timeout
//   data         value sent to the controller
//   address      channel address (0000..0011, 1111 = all)
//   command      controller command code
//   dactrig      one-cycle start pulse
//   dacdone      controller busy; its falling edge ends a transaction
//   busy         FSM is not in IDLE
//   pending      per-channel pending bits
//   err_timeout  sticky handshake timeout flag
module dac_channel_scheduler #(
   parameter int ACK_TIMEOUT  = 64,
   parameter int DONE_TIMEOUT = 2048,
   parameter int TW           = 12
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        wr_en,
   input  logic [1:0]  wr_chan,
   input  logic [11:0] wr_data,
   input  logic        sync_mode,
   input  logic        err_clr,
   output logic [11:0] data,
   output logic [3:0]  address,
   output logic [3:0]  command,
   output logic        dactrig,
   input  logic        dacdone,
   output logic        busy,
   output logic [3:0]  pending,
   output logic        err_timeout
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LAUNCH     = 3'd1;
   localparam logic [2:0] S_LAUNCH_UPD = 3'd2;
   localparam logic [2:0] S_WAIT_ACK   = 3'd3;
   localparam logic [2:0] S_WAIT_DONE  = 3'd4;

   localparam logic [3:0] CMD_WRITE_UPD = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0000;
   localparam logic [3:0] CMD_UPD_ALL   = 4'b0001;
   localparam logic [3:0] CMD_NOP       = 4'b1111;
   localparam logic [3:0] ADDR_ALL      = 4'b1111;

   logic [2:0]        state_q, state_d;
   logic [3:0][11:0]  shadow_q, shadow_d;
   logic [3:0]        pending_q, pending_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic              batch_q, batch_d;
   logic [11:0]       data_q, data_d;
   logic [3:0]        address_q, address_d;
   logic [3:0]        command_q, command_d;
   logic              dactrig_q, dactrig_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [1:0]        sel;
   logic              found;

   // Round-robin pick: scan rr_ptr+1, +2, +3 and finally rr_ptr itself.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!found && pending_q[rr_ptr_q + 2'(i)]) begin
            sel   = rr_ptr_q + 2'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      rr_ptr_d  = rr_ptr_q;
      batch_d   = batch_q;
      data_d    = data_q;
      address_d = address_q;
      command_d = command_q;
      dactrig_d = 1'b0;
      cnt_d     = cnt_q;
      err_d     = err_clr ? 1'b0 : err_q;

      case (state_q)
         // The transaction fields and the trigger are registered on the edge
         // into LAUNCH, so they are on the pins during the LAUNCH cycle and
         // sync_mode is sampled exactly once per transaction.
         S_IDLE: begin
            if (|pending_q) begin
               state_d   = S_LAUNCH;
               data_d    = shadow_q[sel];
               address_d = {2'b00, sel};
               command_d = sync_mode ? CMD_WRITE : CMD_WRITE_UPD;
               dactrig_d = 1'b1;
               rr_ptr_d  = sel;
            end else if (batch_q) begin
               state_d   = S_LAUNCH_UPD;
               address_d = ADDR_ALL;
               command_d = CMD_UPD_ALL;
               dactrig_d = 1'b1;
            end
         end
         S_LAUNCH: begin
            pending_d[address_q[1:0]] = 1'b0;
            // A load-only write owes an update-all later.
            if (command_q == CMD_WRITE) batch_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_LAUNCH_UPD: begin
            batch_d = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (dacdone) begin
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (cnt_q == TW'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!dacdone) begin
               state_d = S_IDLE;
            end else if (cnt_q == TW'(DONE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Applied after the launch clear so a same-cycle write keeps the
      // channel pending and its new value goes out on a later transaction.
      if (wr_en) begin
         shadow_d[wr_chan]  = wr_data;
         pending_d[wr_chan] = 1'b1;
      end
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state_q   <= S_IDLE;
         shadow_q  <= '0;
         pending_q <= '0;
         rr_ptr_q  <= 2'd3;
         batch_q   <= 1'b0;
         data_q    <= '0;
         address_q <= '0;
         command_q <= CMD_NOP;
         dactrig_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         batch_q   <= batch_d;
         data_q    <= data_d;
         address_q <= address_d;
         command_q <= command_d;
         dactrig_q <= dactrig_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign data        = data_q;
   assign address     = address_q;
   assign command     = command_q;
   assign dactrig     = dactrig_q;
   assign busy        = (state_q != S_IDLE);
   assign pending     = pending_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb_dac_channel_scheduler
//   Directed bench for dac_channel_scheduler. A small controller model answers
//   each dactrig (dacdone high 2 cycles later, low 40 cycles after that, or
//   never / stuck high for the timeout cases) and logs every transaction.
//   Each scenario task drives stimulus and compares against hand-computed
//   values.
module tb_dac_channel_scheduler;

   logic        CLK50MHZ = 1'b0;
   logic        RST = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_chan = 2'd0;
   logic [11:0] wr_data = 12'h000;
   logic        sync_mode = 1'b0;
   logic        err_clr = 1'b0;
   logic [11:0] data;
   logic [3:0]  address;
   logic [3:0]  command;
   logic        dactrig;
   logic        dacdone = 1'b0;
   logic        busy;
   logic [3:0]  pending;
   logic        err_timeout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // controller model: 0 = normal, 1 = never acknowledges, 2 = dacdone stuck high
   int mode = 0;
   int ack_cnt = 0;
   int done_cnt = 0;
   int trig_cnt = 0;
   int drop_cyc = 0;
   logic [11:0] log_d[$];
   logic [3:0]  log_a[$];
   logic [3:0]  log_c[$];

   dac_channel_scheduler #(.ACK_TIMEOUT(64), .DONE_TIMEOUT(2048), .TW(12)) dut (
      .CLK50MHZ(CLK50MHZ), .RST(RST), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_data(wr_data), .sync_mode(sync_mode), .err_clr(err_clr),
      .data(data), .address(address), .command(command), .dactrig(dactrig),
      .dacdone(dacdone), .busy(busy), .pending(pending),
      .err_timeout(err_timeout)
   );

   always #10 CLK50MHZ = ~CLK50MHZ;

   always @(posedge CLK50MHZ) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge CLK50MHZ);
         if (dactrig === 1'b1) begin
            trig_cnt++;
            log_d.push_back(data);
            log_a.push_back(address);
            log_c.push_back(command);
            if (mode != 1) ack_cnt = 2;
         end else if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               dacdone  = 1'b1;
               done_cnt = 40;
            end
         end else if (done_cnt > 0 && mode != 2) begin
            done_cnt--;
            if (done_cnt == 0) begin
               dacdone  = 1'b0;
               drop_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK50MHZ);
   endtask

   task automatic wr(input logic [1:0] ch, input logic [11:0] v);
      wr_en = 1'b1; wr_chan = ch; wr_data = v;
      @(negedge CLK50MHZ);
      wr_en = 1'b0;
   endtask

   task automatic pulse_rst();
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
   endtask

   task automatic wait_trig(input string tag);
      int k = 0;
      while (dactrig !== 1'b1 && k < 200) begin
         @(negedge CLK50MHZ);
         k++;
      end
      if (k >= 200) begin
         checks++; errors++;
         $display("FAIL %s_trig_wait: got no dactrig want dactrig within 200 cycles", tag);
      end
   endtask

   task automatic wait_dacdone(input string tag, input logic lvl);
      int k = 0;
      while (dacdone !== lvl && k < 200) begin
         @(negedge CLK50MHZ);
         k++;
      end
      if (k >= 200) begin
         checks++; errors++;
         $display("FAIL %s_dacdone_wait: got %b want %b within 200 cycles", tag, dacdone, lvl);
      end
   endtask

   task automatic wait_quiet(input string tag);
      int k = 0;
      int q = 0;
      while (q < 4 && k < 3000) begin
         @(negedge CLK50MHZ);
         k++;
         if (busy === 1'b0 && pending === 4'h0 && dacdone === 1'b0) q++;
         else q = 0;
      end
      if (k >= 3000) begin
         checks++; errors++;
         $display("FAIL %s_quiet_wait: got busy=%b pending=%h want idle within 3000 cycles", tag, busy, pending);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick(3);
      checks++;
      if ({data, address, command, dactrig, busy, pending, err_timeout} !== {12'h000, 4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h addr=%h cmd=%h trig=%b busy=%b pend=%h err=%b want 000 0 f 0 0 0 0",
                  data, address, command, dactrig, busy, pending, err_timeout);
      end
      RST = 1'b0;
      tick(2);
      checks++;
      if (busy !== 1'b0 || dactrig !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b trig=%b want 0 0", busy, dactrig);
      end
   endtask

   task automatic test_single();
      int n0 = log_d.size();
      int t0 = trig_cnt;
      int k = 0;
      int fall_cyc;
      wr(2'd0, 12'h5F3);
      wait_trig("single");
      while (busy !== 1'b0 && k < 200) begin
         @(negedge CLK50MHZ);
         k++;
      end
      fall_cyc = cyc;
      checks++;
      if (fall_cyc !== drop_cyc + 1) begin
         errors++;
         $display("FAIL single_busy_fall: got cycle %0d want %0d", fall_cyc, drop_cyc + 1);
      end
      wait_quiet("single");
      checks++;
      if (trig_cnt - t0 !== 1) begin
         errors++;
         $display("FAIL single_trig_count: got %0d want 1", trig_cnt - t0);
      end
      checks++;
      if ({log_c[n0], log_a[n0], log_d[n0]} !== {4'h3, 4'h0, 12'h5F3}) begin
         errors++;
         $display("FAIL single_txn: got %h want 305f3", {log_c[n0], log_a[n0], log_d[n0]});
      end
      checks++;
      if (pending !== 4'h0) begin
         errors++;
         $display("FAIL single_pending: got %h want 0", pending);
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] exp1 [4];
      logic [15:0] exp2 [3];
      int n0, n1;
      pulse_rst();
      n0 = log_d.size();
      // ch3 occupies the controller (rr_ptr becomes 3) while ch2, ch0, ch3 queue up
      wr(2'd3, 12'h0AA);
      wait_trig("rr1");
      wait_dacdone("rr1", 1'b1);
      wr(2'd2, 12'h3F5);
      wr(2'd0, 12'h111);
      wr(2'd3, 12'h0CC);
      wait_quiet("rr1");
      exp1[0] = {4'h3, 12'h0AA};
      exp1[1] = {4'h0, 12'h111};
      exp1[2] = {4'h2, 12'h3F5};
      exp1[3] = {4'h3, 12'h0CC};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({log_a[n0 + i], log_d[n0 + i]} !== exp1[i]) begin
            errors++;
            $display("FAIL rr1_order[%0d]: got %h want %h", i, {log_a[n0 + i], log_d[n0 + i]}, exp1[i]);
         end
      end
      // ch0 served (rr_ptr=0), ch0 and ch2 re-pend: ch2 must go before ch0
      n1 = log_d.size();
      wr(2'd0, 12'h001);
      wait_trig("rr2");
      wait_dacdone("rr2", 1'b1);
      wr(2'd0, 12'h002);
      wr(2'd2, 12'h222);
      wait_quiet("rr2");
      exp2[0] = {4'h0, 12'h001};
      exp2[1] = {4'h2, 12'h222};
      exp2[2] = {4'h0, 12'h002};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({log_a[n1 + i], log_d[n1 + i]} !== exp2[i]) begin
            errors++;
            $display("FAIL rr2_order[%0d]: got %h want %h", i, {log_a[n1 + i], log_d[n1 + i]}, exp2[i]);
         end
      end
   endtask

   task automatic test_sync_batch();
      logic [19:0] expv [3];
      int n0, t0;
      int k = 0;
      pulse_rst();
      n0 = log_d.size();
      t0 = trig_cnt;
      sync_mode = 1'b1;
      wr(2'd1, 12'h123);
      wr(2'd3, 12'h456);
      // drop sync_mode during the second load; the update-all must still follow
      while (trig_cnt < t0 + 2 && k < 500) begin
         @(negedge CLK50MHZ);
         k++;
      end
      sync_mode = 1'b0;
      wait_quiet("sync");
      checks++;
      if (trig_cnt - t0 !== 3) begin
         errors++;
         $display("FAIL sync_trig_count: got %0d want 3", trig_cnt - t0);
      end
      expv[0] = {4'h0, 4'h1, 12'h123};
      expv[1] = {4'h0, 4'h3, 12'h456};
      expv[2] = {4'h1, 4'hF, 12'h456};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({log_c[n0 + i], log_a[n0 + i], log_d[n0 + i]} !== expv[i]) begin
            errors++;
            $display("FAIL sync_txn[%0d]: got %h want %h", i, {log_c[n0 + i], log_a[n0 + i], log_d[n0 + i]}, expv[i]);
         end
      end
   endtask

   task automatic test_rewrite();
      int n0, n1;
      n0 = log_d.size();
      wr(2'd1, 12'h100);
      wait_trig("rewr");
      wait_dacdone("rewr", 1'b1);
      wr(2'd1, 12'h7FF);
      wait_quiet("rewr");
      checks++;
      if ({log_a[n0], log_d[n0], log_a[n0 + 1], log_d[n0 + 1]} !== {4'h1, 12'h100, 4'h1, 12'h7FF}) begin
         errors++;
         $display("FAIL rewrite_wait_done: got %h want 11001 17ff",
                  {log_a[n0], log_d[n0], log_a[n0 + 1], log_d[n0 + 1]});
      end
      // write landing on the LAUNCH edge of the same channel
      n1 = log_d.size();
      wr(2'd1, 12'h200);
      wait_trig("launchwr");
      wr(2'd1, 12'h333);
      checks++;
      if (pending[1] !== 1'b1 || data !== 12'h200) begin
         errors++;
         $display("FAIL launch_write: got pending=%h data=%h want pending[1]=1 data=200", pending, data);
      end
      wait_quiet("launchwr");
      checks++;
      if ({log_a[n1], log_d[n1], log_a[n1 + 1], log_d[n1 + 1]} !== {4'h1, 12'h200, 4'h1, 12'h333}) begin
         errors++;
         $display("FAIL launch_write_txns: got %h want 1200 1333",
                  {log_a[n1], log_d[n1], log_a[n1 + 1], log_d[n1 + 1]});
      end
   endtask

   task automatic test_ack_timeout();
      int n0 = log_d.size();
      mode = 1;
      wr(2'd1, 12'h0A1);
      wait_trig("acktmo");
      tick(10);
      wr(2'd2, 12'h0A2);
      tick(53);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout_early: got err=%b busy=%b at 64 cycles want 0 1", err_timeout, busy);
      end
      tick(1);
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || pending !== 4'b0100) begin
         errors++;
         $display("FAIL ack_timeout: got err=%b busy=%b pend=%h at 65 cycles want 1 0 4", err_timeout, busy, pending);
      end
      mode = 0;
      wait_quiet("acktmo");
      checks++;
      if ({log_a[n0 + 1], log_d[n0 + 1], err_timeout} !== {4'h2, 12'h0A2, 1'b1}) begin
         errors++;
         $display("FAIL ack_timeout_next: got addr=%h data=%h err=%b want 2 0a2 1",
                  log_a[n0 + 1], log_d[n0 + 1], err_timeout);
      end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL err_clr: got %b want 0", err_timeout);
      end
   endtask

   task automatic test_done_timeout();
      int k = 0;
      mode = 2;
      wr(2'd3, 12'h0B3);
      wait_trig("donetmo");
      while (err_timeout !== 1'b1 && k < 2300) begin
         @(negedge CLK50MHZ);
         k++;
      end
      // trig at T, dacdone seen at T+3, 2048 WAIT_DONE cycles, flag at T+2051
      checks++;
      if (k !== 2051 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_timeout: got flag after %0d cycles busy=%b want 2051 0", k, busy);
      end
      mode = 0;
      wait_quiet("donetmo");
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0 || pending !== 4'h0) begin
         errors++;
         $display("FAIL done_timeout_clr: got err=%b pend=%h want 0 0", err_timeout, pending);
      end
   endtask

   task automatic test_reset_mid();
      int n0 = log_d.size();
      int t0 = trig_cnt;
      wr(2'd2, 12'h0AB);
      wait_trig("rstmid");
      wait_dacdone("rstmid", 1'b1);
      tick(5);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      checks++;
      if ({data, address, command, dactrig, busy, pending, err_timeout} !== {12'h000, 4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got data=%h addr=%h cmd=%h trig=%b busy=%b pend=%h err=%b want 000 0 f 0 0 0 0",
                  data, address, command, dactrig, busy, pending, err_timeout);
      end
      tick(3);
      checks++;
      if (busy !== 1'b0 || dacdone !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ignore: got busy=%b dacdone=%b want 0 1", busy, dacdone);
      end
      wait_dacdone("rstmid", 1'b0);
      tick(2);
      wr(2'd0, 12'h321);
      wait_quiet("rstmid");
      checks++;
      if ({trig_cnt - t0, log_c[n0 + 1], log_a[n0 + 1], log_d[n0 + 1]} !== {32'd2, 4'h3, 4'h0, 12'h321}) begin
         errors++;
         $display("FAIL reset_mid_after: got trigs=%0d txn=%h want 2 30321",
                  trig_cnt - t0, {log_c[n0 + 1], log_a[n0 + 1], log_d[n0 + 1]});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_sync_batch();
      test_rewrite();
      test_ack_timeout();
      test_done_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
